// File: rtl/siso_pkg.sv
// rtl/siso_pkg.sv - shared state encoding and counter width helper for the SISO shift controller
package siso_pkg;

    // Controller state encoding
    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
    localparam logic [1:0] CHECK = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

    // Width of a counter that has to reach n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/siso_bit_counter.sv
// rtl/siso_bit_counter.sv - saturating bit counter for the SHIFT phase
//
// Ports:
//   clk, reset_al_in : clock, asynchronous active-low reset
//   clear            : force count to 0 (priority over enable)
//   enable           : advance count by one
//   count            : current bit index
//   last             : count has reached N-1; counting stops there
module siso_bit_counter
    import siso_pkg::*;
#(
    parameter int N  = 16,
    parameter int CW = cnt_width(N)
) (
    input  logic          clk,
    input  logic          reset_al_in,
    input  logic          clear,
    input  logic          enable,
    output logic [CW-1:0] count,
    output logic          last
);

    localparam logic [CW-1:0] LAST_IDX = CW'(N - 1);

    assign last = (count == LAST_IDX);

    // Saturates at N-1 so a stray enable can never wrap the index.
    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !last) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/siso_nbit.sv
// rtl/siso_nbit.sv - N-bit serial-in parallel-out shift register driven by the controller
//
// Ports:
//   clk, reset_al_in : clock, asynchronous active-low reset
//   shift_en         : shift one position towards the MSB
//   d_in             : serial bit entering at the LSB
//   q                : parallel contents
module siso_nbit #(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset_al_in,
    input  logic         shift_en,
    input  logic         d_in,
    output logic [N-1:0] q
);

    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            q <= '0;
        end else if (shift_en) begin
            q <= {q[N-2:0], d_in};
        end
    end

endmodule

// File: rtl/siso_shift_ctrl.sv
// rtl/siso_shift_ctrl.sv - serializes a word MSB-first into a shift register, optional readback check
//
// Optional feature macro: SISO_SHIFT_CTRL_READBACK_EN (adds the CHECK state and err_out).
//
// Ports:
//   clk, reset_al_in : clock, asynchronous active-low reset
//   start_in/data_in : request to serialize data_in (taken only in IDLE)
//   abort_in         : cancel the transfer in progress; also blocks a start in IDLE
//   q_in             : parallel readback of the attached shift register
//   ready_out        : high in IDLE
//   shift_en_out     : shift enable to the register, high for N cycles
//   d_out            : serial bit to the register
//   done_out         : one-cycle completion pulse
//   err_out          : readback mismatch flag, held until the next check
module siso_shift_ctrl
    import siso_pkg::*;
#(
    parameter int N = 16
) (
    input  logic         clk,
    input  logic         reset_al_in,
    input  logic         start_in,
    input  logic [N-1:0] data_in,
    input  logic         abort_in,
    input  logic [N-1:0] q_in,
    output logic         ready_out,
    output logic         shift_en_out,
    output logic         d_out,
    output logic         done_out,
    output logic         err_out
);

    localparam int              CW       = cnt_width(N);
    localparam logic [CW-1:0]   LAST_IDX = CW'(N - 1);

    logic [1:0]    state;
    logic [1:0]    state_nxt;
    logic [N-1:0]  word;
    logic [CW-1:0] count;
    logic          last;
    logic          accept;

    assign accept = (state == IDLE) && start_in && !abort_in;

    // Holding the counter cleared outside SHIFT guarantees it starts at 0 on entry.
    siso_bit_counter #(.N(N), .CW(CW)) u_bit_counter (
        .clk         (clk),
        .reset_al_in (reset_al_in),
        .clear       (state != SHIFT),
        .enable      (state == SHIFT),
        .count       (count),
        .last        (last)
    );

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (abort_in) begin
                    state_nxt = IDLE;
                end else if (last) begin
`ifdef SISO_SHIFT_CTRL_READBACK_EN
                    state_nxt = CHECK;
`else
                    state_nxt = DONE;
`endif
                end
            end
            CHECK: begin
                state_nxt = abort_in ? IDLE : DONE;
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            state <= IDLE;
            word  <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                word <= data_in;
            end
        end
    end

    assign ready_out    = (state == IDLE);
    assign shift_en_out = (state == SHIFT);
    // Bit N-1-k in SHIFT cycle k, so the register holds the word after N shifts.
    assign d_out        = shift_en_out ? word[LAST_IDX - count] : 1'b0;
    // An abort in DONE cancels the pulse in the same cycle.
    assign done_out     = (state == DONE) && !abort_in;

`ifdef SISO_SHIFT_CTRL_READBACK_EN
    logic err;

    // An abort during CHECK leaves the previous verdict untouched.
    always_ff @(posedge clk or negedge reset_al_in) begin
        if (!reset_al_in) begin
            err <= 1'b0;
        end else if ((state == CHECK) && !abort_in) begin
            err <= (q_in != word);
        end
    end

    assign err_out = err;
`else
    logic unused_q;

    assign unused_q = ^q_in;
    assign err_out  = 1'b0;
`endif

endmodule

// File: tb/tb_siso_shift_ctrl.sv
// tb/tb_siso_shift_ctrl.sv - directed self-checking bench for siso_shift_ctrl with siso_nbit
module tb_siso_shift_ctrl;

    localparam int N = 16;
`ifdef SISO_SHIFT_CTRL_READBACK_EN
    localparam int LAT = N + 2;
    localparam bit RB  = 1'b1;
`else
    localparam int LAT = N + 1;
    localparam bit RB  = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         reset_al_in;
    logic         start_in;
    logic [N-1:0] data_in;
    logic         abort_in;
    logic [N-1:0] q_in;
    logic [N-1:0] sr_q;
    logic         ready_out;
    logic         shift_en_out;
    logic         d_out;
    logic         done_out;
    logic         err_out;
    logic         force_q;
    logic         exp_err;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    siso_shift_ctrl #(.N(N)) dut (
        .clk          (clk),
        .reset_al_in  (reset_al_in),
        .start_in     (start_in),
        .data_in      (data_in),
        .abort_in     (abort_in),
        .q_in         (q_in),
        .ready_out    (ready_out),
        .shift_en_out (shift_en_out),
        .d_out        (d_out),
        .done_out     (done_out),
        .err_out      (err_out)
    );

    siso_nbit #(.N(N)) u_sr (
        .clk         (clk),
        .reset_al_in (reset_al_in),
        .shift_en    (shift_en_out),
        .d_in        (d_out),
        .q           (sr_q)
    );

    // Corrupting the LSB turns A5C3 into A5C2 while the controller checks.
    assign q_in = force_q ? (sr_q ^ 16'h0001) : sr_q;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_ready"},    ready_out,    1);
        check({tag, "_shift_en"}, shift_en_out, 0);
        check({tag, "_d_out"},    d_out,        0);
        check({tag, "_done"},     done_out,     0);
        check({tag, "_err"},      err_out,      0);
    endtask

    // Full transfer started from IDLE at a negedge; bad=1 corrupts q_in during CHECK.
    task automatic transfer(input logic [N-1:0] w, input bit bad);
        data_in  = w;
        start_in = 1'b1;
        for (int cyc = 1; cyc <= LAT + 1; cyc++) begin
            @(negedge clk);
            if (cyc == 1) start_in = 1'b0;
            force_q = 1'b0;
            if (cyc <= N) begin
                check("shift_en", shift_en_out, 1);
                check("d_out", d_out, w[N-cyc]);
                check("ready_busy", ready_out, 0);
                check("done_in_shift", done_out, 0);
                if (cyc == 1) check("err_held_into_shift", err_out, exp_err);
            end else if (cyc < LAT) begin
                check("check_shift_en", shift_en_out, 0);
                check("check_d_out", d_out, 0);
                check("check_readback", q_in, w);
                check("check_done", done_out, 0);
                if (bad) force_q = 1'b1;
            end else if (cyc == LAT) begin
                if (RB) exp_err = bad;
                check("done_pulse", done_out, 1);
                check("done_err", err_out, exp_err);
                check("done_ready", ready_out, 0);
            end else begin
                check("done_cleared", done_out, 0);
                check("ready_back", ready_out, 1);
                check("err_after_done", err_out, exp_err);
            end
        end
    endtask

    initial begin
        int dones;
        int shifts;
        bit seen;

        reset_al_in = 1'b0;
        start_in    = 1'b0;
        abort_in    = 1'b0;
        data_in     = '0;
        force_q     = 1'b0;
        exp_err     = 1'b0;

        // Reset held low for 50 ns
        #1;
        check_reset_outputs("reset");
        repeat (5) @(negedge clk);
        check_reset_outputs("reset_end");
        reset_al_in = 1'b1;
        @(negedge clk);
        check("idle_ready", ready_out, 1);

        // Good transfer, then a readback mismatch
        transfer(16'hA5C3, 1'b0);
        transfer(16'hA5C3, 1'b1);
        repeat (4) @(negedge clk);
        check("err_held_idle", err_out, exp_err);

        // Abort in SHIFT cycle 5
        data_in  = 16'h1234;
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        repeat (5) @(negedge clk);
        check("abort_pre_shift_en", shift_en_out, 1);
        abort_in = 1'b1;
        @(negedge clk);
        abort_in = 1'b0;
        check("abort_ready", ready_out, 1);
        check("abort_shift_en", shift_en_out, 0);
        check("abort_d_out", d_out, 0);
        check("abort_done", done_out, 0);
        check("abort_err_kept", err_out, exp_err);
        dones = 0;
        shifts = 0;
        repeat (20) begin
            @(negedge clk);
            if (done_out) dones++;
            if (shift_en_out) shifts++;
        end
        check("abort_no_done", dones, 0);
        check("abort_no_restart", shifts, 0);

        // Start and abort together in IDLE
        data_in  = 16'hFFFF;
        start_in = 1'b1;
        abort_in = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("start_abort_ready", ready_out, 1);
            check("start_abort_shift_en", shift_en_out, 0);
        end
        start_in = 1'b0;
        abort_in = 1'b0;

        // Asynchronous reset in the middle of SHIFT
        data_in  = 16'hFFFF;
        start_in = 1'b1;
        @(negedge clk);
        start_in = 1'b0;
        repeat (5) @(negedge clk);
        check("pre_reset_shift_en", shift_en_out, 1);
        check("pre_reset_d_out", d_out, 1);
        #2;
        reset_al_in = 1'b0;
        #1;
        exp_err = 1'b0;
        check_reset_outputs("async_reset");
        dones = 0;
        repeat (10) begin
            @(negedge clk);
            if (done_out) dones++;
        end
        check("reset_no_done", dones, 0);
        reset_al_in = 1'b1;
        transfer(16'h0F0E, 1'b0);

        // start_in held high: one word per IDLE visit
        data_in  = 16'h3C96;
        start_in = 1'b1;
        shifts = 0;
        for (int cyc = 1; cyc <= LAT + 2; cyc++) begin
            @(negedge clk);
            if (cyc == 1) data_in = 16'hEB21;
            if (cyc <= LAT && shift_en_out) shifts++;
            if (cyc == 2) check("held_first_word", d_out, 0);
            if (cyc == LAT) check("held_done", done_out, 1);
            if (cyc == LAT + 1) begin
                check("held_idle_ready", ready_out, 1);
                check("held_idle_shift_en", shift_en_out, 0);
            end
            if (cyc == LAT + 2) begin
                check("held_second_accept", shift_en_out, 1);
                check("held_second_ready", ready_out, 0);
                check("held_second_msb", d_out, 1);
            end
        end
        check("held_single_word_shifts", shifts, N);
        start_in = 1'b0;
        seen = 1'b0;
        for (int cyc = 0; cyc < 40 && !seen; cyc++) begin
            @(negedge clk);
            if (done_out) seen = 1'b1;
        end
        check("held_second_done", seen, 1);
        check("held_second_err", err_out, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/siso_shift_ctrl.md
SISO_SHIFT_CTRL -- requirements
Module: siso_shift_ctrl

Interface
REQ-001 SHALL have parameter N, default 16, which is the width of the attached serial-in shift register and of the data word.
REQ-002 SHALL have port clk, input, 1 bit, the sole clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_al_in, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have port start_in, input, 1 bit, request to serialize data_in.
REQ-005 SHALL have port data_in, input, N bits, the word to shift out.
REQ-006 SHALL have port abort_in, input, 1 bit, cancel the operation in progress.
REQ-007 SHALL have port q_in, input, N bits, parallel output of the attached shift register.
REQ-008 SHALL have port ready_out, output, 1 bit, high when a start is accepted.
REQ-009 SHALL have port shift_en_out, output, 1 bit, shift enable to the register.
REQ-010 SHALL have port d_out, output, 1 bit, serial bit driven to the register's d_in.
REQ-011 SHALL have port done_out, output, 1 bit, one-cycle completion pulse.
REQ-012 SHALL have port err_out, output, 1 bit, readback mismatch flag (see Configuration).

Function
REQ-013 SHALL implement states IDLE, SHIFT, CHECK and DONE.
REQ-014 SHALL hold ready_out=1 only in IDLE.
REQ-015 SHALL accept the word only when start_in=1, abort_in=0 and state=IDLE: latch data_in and go to SHIFT on the next edge.
REQ-016 SHALL ignore start_in in every state other than IDLE.
REQ-017 SHALL stay in SHIFT for exactly N cycles with shift_en_out=1.
REQ-018 SHALL drive d_out MSB-first: bit N-1-k of the latched word in SHIFT cycle k (k=0..N-1), so that q_in equals the word after N shifts.
REQ-019 SHALL drive shift_en_out=0 and d_out=0 outside SHIFT.
REQ-020 SHALL use a bit counter of width $clog2(N), clear it on entry to SHIFT, and leave SHIFT when the count equals N-1 with no wrap-around beyond that.
REQ-021 SHALL transition SHIFT->CHECK->DONE->IDLE, each of CHECK and DONE lasting one cycle.
REQ-022 SHALL assert done_out=1 only in DONE.
REQ-023 SHALL, when abort_in=1 in SHIFT, CHECK or DONE, go to IDLE on the next edge, suppress done_out and leave err_out unchanged.
REQ-024 SHALL, when abort_in=1 and start_in=1 arrive together in IDLE, let abort win and not accept the start.
REQ-025 SHALL give a latency from accepted start to the done_out pulse of N+2 cycles when the readback check is compiled in, and N+1 cycles otherwise.

Reset
REQ-026 SHALL, while reset_al_in=0, immediately force state=IDLE, counter=0, latched word=0, ready_out=1, shift_en_out=0, d_out=0, done_out=0 and err_out=0.
REQ-027 SHALL abandon an in-flight transfer on reset without a done_out pulse, and SHALL resume operation on the first clk edge after reset deasserts.

Configuration
REQ-028 SHALL, with SISO_SHIFT_CTRL_READBACK_EN defined, compare q_in to the latched word in CHECK and register the result into err_out (1 on mismatch, 0 on match), holding it until the next CHECK or reset.
REQ-029 SHALL, without SISO_SHIFT_CTRL_READBACK_EN, omit the CHECK state (SHIFT->DONE directly), tie err_out to 0 and ignore q_in.

Structure
REQ-030 SHALL take the state encoding constants (IDLE=0, SHIFT=1, CHECK=2, DONE=3) and the counter-width function from the shared package siso_pkg.
REQ-031 SHALL place the bit counter in the sub-module siso_bit_counter (inputs: clear, enable; output: count; flag: last).

Verification (N=16, bench instantiates siso_shift_ctrl with siso_nbit)
REQ-032 SHALL cover: reset low 50 ns, then start with data_in=16'hA5C3 -> d_out sequence 1010_0101_1100_0011 over 16 cycles with shift_en_out=1, q_in=16'hA5C3, done_out pulse 18 cycles after the start (READBACK_EN), err_out=0.
REQ-033 SHALL cover: same transfer with q_in forced to 16'hA5C2 during CHECK -> err_out=1 at DONE, held until the next transfer.
REQ-034 SHALL cover: abort_in pulsed in SHIFT cycle 5 -> IDLE next cycle, shift_en_out=0, no done_out, ready_out=1.
REQ-035 SHALL cover: start_in held high through a transfer -> exactly one word accepted per IDLE visit, second accepted the cycle after DONE.
REQ-036 SHALL cover: start_in=1 and abort_in=1 together in IDLE -> ready_out stays 1, no shift activity.
REQ-037 SHALL cover: reset_al_in=0 asserted mid-SHIFT -> all outputs take their reset values asynchronously and no done_out pulse occurs.
